// File: rtl/f_scan_pkg.sv
// Shared definitions for the inverse-scan block.
//   state_t  : scan controller states (IDLE, SCAN, DONE)
//   N_COMB   : number of input combinations walked per scan
//   IDX_W    : width of the combination index {a,b,c}
//   LAST_IDX : final index of a scan, where the walk stops
package f_scan_pkg;

  localparam int N_COMB = 8;
  localparam int IDX_W  = 3;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SCAN = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_COMB - 1);

endpackage

// File: rtl/f_eval.sv
// Combinational evaluator of the scanned boolean function.
//   a, b, c : function inputs (a is the MSB of the scan index)
//   s       : (a AND NOT c) OR (a AND NOT b AND c), i.e. a AND NOT(b AND c)
module f_eval (
  input  logic a,
  input  logic b,
  input  logic c,
  output logic s
);

  assign s = (a & ~c) | (a & ~b & c);

endmodule

// File: rtl/f_inverse_scan.sv
// Walks all 8 combinations of {a,b,c}, one per cycle, and reports which of
// them make f_eval's output equal a requested target value.
//   clk          : clock, all state updates on the rising edge
//   rst_n        : asynchronous active-low reset
//   start        : scan request, only honoured in IDLE
//   target       : required value of s, latched when start is accepted
//   busy         : high in SCAN and DONE
//   done         : one-cycle pulse, results valid
//   found        : at least one combination matched
//   match_abc    : lowest matching {a,b,c}, 0 when nothing matched
//   minterm_mask : bit i is s for {a,b,c} = i
//   match_count  : number of matching combinations (0..8)
module f_inverse_scan
  import f_scan_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             target,
  output logic             busy,
  output logic             done,
  output logic             found,
  output logic [IDX_W-1:0] match_abc,
  output logic [N_COMB-1:0] minterm_mask,
  output logic [3:0]       match_count
);

  state_t           state_reg;
  state_t           state_next;
  logic [IDX_W-1:0] idx_reg;
  logic             target_reg;
  logic             found_reg;
  logic [IDX_W-1:0] abc_reg;
  logic [3:0]       count_reg;
  logic [N_COMB-1:0] mask_reg;
  logic             s;
  logic             accept;
  logic             scanning;
  logic             hit;

  f_eval u_eval (
    .a (idx_reg[2]),
    .b (idx_reg[1]),
    .c (idx_reg[0]),
    .s (s)
  );

  assign accept   = (state_reg == IDLE) && start;
  assign scanning = (state_reg == SCAN);
  assign hit      = scanning && (s == target_reg);

  // ---------------- FSM: state register ----------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_reg <= IDLE;
    else        state_reg <= state_next;
  end

  // ---------------- FSM: next state ----------------
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (start) state_next = SCAN;
      SCAN:    if (idx_reg == LAST_IDX) state_next = DONE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // ---------------- FSM: outputs ----------------
  always_comb begin
    busy = 1'b0;
    done = 1'b0;
    case (state_reg)
      SCAN:    busy = 1'b1;
      DONE:    begin busy = 1'b1; done = 1'b1; end
      default: ;
    endcase
  end

  // ---------------- Index, target and match bookkeeping ----------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idx_reg    <= '0;
      target_reg <= 1'b0;
      found_reg  <= 1'b0;
      abc_reg    <= '0;
      count_reg  <= 4'd0;
    end else if (accept) begin
      idx_reg    <= '0;
      target_reg <= target;
      found_reg  <= 1'b0;
      abc_reg    <= '0;
      count_reg  <= 4'd0;
    end else if (scanning) begin
      // Index saturates at the last combination rather than wrapping.
      if (idx_reg != LAST_IDX) idx_reg <= idx_reg + 1'b1;
      if (hit) begin
        count_reg <= count_reg + 4'd1;
        // Only the first (lowest) matching index is recorded.
        if (!found_reg) begin
          found_reg <= 1'b1;
          abc_reg   <= idx_reg;
        end
      end
    end
  end

  // ---------------- Minterm mask, one flop per combination ----------------
  generate
    for (genvar gi = 0; gi < N_COMB; gi++) begin : g_mask
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                                      mask_reg[gi] <= 1'b0;
        else if (accept)                                 mask_reg[gi] <= 1'b0;
        else if (scanning && (idx_reg == IDX_W'(gi)))    mask_reg[gi] <= s;
      end
    end
  endgenerate

  assign found        = found_reg;
  assign match_abc    = abc_reg;
  assign minterm_mask = mask_reg;
  assign match_count  = count_reg;

endmodule

// File: tb/tb_f_inverse_scan.sv
module tb_f_inverse_scan;
  import f_scan_pkg::*;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  logic       target = 1'b0;
  logic       busy, done, found;
  logic [2:0] match_abc;
  logic [7:0] minterm_mask;
  logic [3:0] match_count;

  logic ea = 1'b0, eb = 1'b0, ec = 1'b0;
  logic es;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct packed {
    logic [7:0] mask;
    logic       found;
    logic [2:0] abc;
    logic [3:0] count;
  } res_t;

  typedef struct {
    logic tgt;
    res_t exp_r;
  } scan_vec_t;

  typedef struct {
    logic [2:0] abc;
    logic       s;
  } tt_vec_t;

  res_t sb[$];

  always #5 clk = ~clk;

  f_inverse_scan dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .start        (start),
    .target       (target),
    .busy         (busy),
    .done         (done),
    .found        (found),
    .match_abc    (match_abc),
    .minterm_mask (minterm_mask),
    .match_count  (match_count)
  );

  f_eval u_eval_chk (.a(ea), .b(eb), .c(ec), .s(es));

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end else begin
      $display("ok   %s: 0x%0h", name, act);
    end
  endtask

  task automatic check_res(input string name, input res_t exp_r);
    check({name, ".mask"},  minterm_mask, exp_r.mask);
    check({name, ".found"}, found,        exp_r.found);
    check({name, ".abc"},   match_abc,    exp_r.abc);
    check({name, ".count"}, match_count,  exp_r.count);
  endtask

  task automatic check_zero(input string name);
    check(name, {busy, done, found, match_abc, minterm_mask, match_count}, 32'd0);
  endtask

  // Reference model built from the sum-of-products form of the function.
  function automatic res_t model(input logic tgt);
    res_t r;
    logic a, b, c, s;
    r = '0;
    for (int i = 0; i < 8; i++) begin
      a = i[2]; b = i[1]; c = i[0];
      s = (a & ~c) | (a & ~b & c);
      r.mask[i] = s;
      if (s == tgt) begin
        r.count = r.count + 4'd1;
        if (!r.found) begin
          r.found = 1'b1;
          r.abc   = i[2:0];
        end
      end
    end
    return r;
  endfunction

  // One scan: start accepted at the edge after the first negedge; done is
  // expected in the 9th cycle after that edge. With toggle set, target flips
  // in cycles 2 and 5 and an extra start pulse is offered in cycle 3.
  task automatic do_scan(input string name, input logic tgt, input res_t exp_r, input bit toggle);
    int   cyc;
    bit   seen;
    res_t got;
    @(negedge clk);
    start  = 1'b1;
    target = tgt;
    sb.push_back(exp_r);
    @(negedge clk);
    start = 1'b0;
    check({name, ".busy"}, busy, 1'b1);
    cyc  = 1;
    seen = 1'b0;
    while (!seen && cyc <= 15) begin
      if (done) begin
        seen = 1'b1;
        check({name, ".latency"}, cyc, 9);
        got = sb.pop_front();
        check_res(name, got);
      end else begin
        if (toggle) begin
          if (cyc == 2 || cyc == 5) target = ~target;
          start = (cyc == 3);
        end
        @(negedge clk);
        cyc++;
      end
    end
    start = 1'b0;
    if (!seen) begin
      n_checks++;
      n_fail++;
      $display("FAIL %s.timeout: no done within 15 cycles", name);
      sb.delete();
    end
    @(negedge clk);
    check({name, ".done_single"}, done, 1'b0);
    check({name, ".idle"}, busy, 1'b0);
    check_res({name, ".hold"}, exp_r);
  endtask

  initial begin
    tt_vec_t   tt[8];
    scan_vec_t sv[2];
    int        pulses;

    tt[0] = '{3'b000, 1'b0}; tt[1] = '{3'b001, 1'b0};
    tt[2] = '{3'b010, 1'b0}; tt[3] = '{3'b011, 1'b0};
    tt[4] = '{3'b100, 1'b1}; tt[5] = '{3'b101, 1'b1};
    tt[6] = '{3'b110, 1'b1}; tt[7] = '{3'b111, 1'b0};

    sv[0] = '{1'b1, '{mask: 8'h70, found: 1'b1, abc: 3'b100, count: 4'd3}};
    sv[1] = '{1'b0, '{mask: 8'h70, found: 1'b1, abc: 3'b000, count: 4'd5}};

    // Reset state
    #2;
    check_zero("reset_state");
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check_zero("post_reset_idle");

    // Truth table of the evaluator
    for (int i = 0; i < 8; i++) begin
      {ea, eb, ec} = tt[i].abc;
      #1;
      check($sformatf("f_eval[%0d]", i), es, tt[i].s);
    end

    // Table-driven scans
    for (int i = 0; i < 2; i++)
      do_scan($sformatf("scan_tgt%0d", sv[i].tgt), sv[i].tgt, sv[i].exp_r, 1'b0);

    // Target toggling and ignored start during a scan
    do_scan("toggle", 1'b1, model(1'b1), 1'b1);
    pulses = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (done) pulses++;
    end
    check("no_queued_start", pulses, 0);

    // Reset in the middle of a scan (index 4 evaluated in cycle 5)
    @(negedge clk);
    start  = 1'b1;
    target = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (4) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check_zero("midscan_reset");
    @(negedge clk);
    rst_n = 1'b1;
    pulses = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (done) pulses++;
      if (i == 0 || i == 11) check_zero($sformatf("after_reset_c%0d", i));
    end
    check("after_reset_no_done", pulses, 0);
    do_scan("post_reset_scan", 1'b1, model(1'b1), 1'b0);

    // Continuous start: accepts at the end of cycles 0, 10, 20
    @(negedge clk);
    start  = 1'b1;
    target = 1'b0;
    sb.push_back(model(1'b0));
    for (int c = 1; c <= 30; c++) begin
      @(negedge clk);
      if (c == 10 || c == 20) sb.push_back(model(1'b0));
      check($sformatf("hold_done_c%0d", c), done, ((c % 10) == 9));
      if (done) begin
        if (sb.size() > 0) check_res($sformatf("hold_res_c%0d", c), sb.pop_front());
        else begin
          n_checks++;
          n_fail++;
          $display("FAIL hold_extra_done: unexpected done at cycle %0d", c);
        end
      end
      if ((c % 10) == 0) check_res($sformatf("hold_stable_c%0d", c), model(1'b0));
      if (c == 25) start = 1'b0;
    end
    check("hold_sb_empty", sb.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
